// File: rtl/opendap_sw_dp_regs.sv
// opendap_sw_dp_regs: SW-DP register file, sticky error flags
// and single-outstanding posted AP access sequencer.
module opendap_sw_dp_regs #(
  parameter logic [31:0] DPIDR     = 32'h0bc12477,
  parameter logic [31:0] TARGETID  = 32'h00000001,
  parameter logic [31:0] DLPIDR    = 32'h00000001,
  parameter logic [3:0]  TINSTANCE = 4'h0
) (
  input  logic        swclk,
  input  logic        rst,
  input  logic [1:0]  bus_addr,
  input  logic        bus_r_nw,
  input  logic        bus_ap_ndp,
  input  logic [31:0] bus_wdata,
  input  logic        bus_en,
  output logic [31:0] bus_rdata,
  output logic [31:0] targetsel_expected,
  input  logic        dp_set_wdataerr,
  input  logic        dp_set_stickyorun,
  input  logic        dp_clear_readok,
  output logic        dp_orundetect,
  output logic        dp_acc_fault,
  output logic        dp_acc_wait,
  output logic        dp_acc_protocol_err,
  output logic        ap_en,
  output logic [7:0]  ap_sel,
  output logic [5:0]  ap_addr,
  output logic        ap_r_nw,
  output logic [31:0] ap_wdata,
  input  logic        ap_rdy,
  input  logic [31:0] ap_rdata,
  input  logic        ap_err,
  output logic        ap_abort,
  output logic        cdbgpwrupreq,
  output logic        csyspwrupreq,
  input  logic        cdbgpwrupack,
  input  logic        csyspwrupack
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ap_state_e;

  ap_state_e state_q, state_d;

  logic        orundetect_q;
  logic        stickyorun_q;
  logic        stickyerr_q;
  logic        readok_q;
  logic        wdataerr_q;
  logic        cdbg_req_q;
  logic        csys_req_q;
  logic        ap_abort_q;
  logic        rd_pend_q;
  logic [7:0]  apsel_q;
  logic [3:0]  apbanksel_q;
  logic [3:0]  dpbanksel_q;
  logic [31:0] rdbuff_q;

  logic        busy;
  logic        dp_wr;
  logic        abort_wr;
  logic        ctrl_wr;
  logic        select_wr;
  logic        dap_abort;
  logic        ap_done;
  logic [31:0] ctrl_stat;
  logic [31:0] bank_rdata;

  assign busy      = (state_q == BUSY);
  assign dp_wr     = bus_en & ~bus_ap_ndp & ~bus_r_nw;
  assign abort_wr  = dp_wr & (bus_addr == 2'd0);
  assign ctrl_wr   = dp_wr & (bus_addr == 2'd1)
                   & (dpbanksel_q == 4'd0);
  assign select_wr = dp_wr & (bus_addr == 2'd2);
  assign dap_abort = abort_wr & bus_wdata[0];
  // A DAPABORT in the completion cycle discards the result.
  assign ap_done   = busy & ap_rdy & ~dap_abort;

  assign ctrl_stat = {
    csyspwrupack, csys_req_q,
    cdbgpwrupack, cdbg_req_q,
    20'd0,
    wdataerr_q, readok_q, stickyerr_q,
    3'd0,
    stickyorun_q, orundetect_q
  };

  assign targetsel_expected = {TINSTANCE, TARGETID[27:0]};

  assign dp_orundetect = orundetect_q;
  assign cdbgpwrupreq  = cdbg_req_q;
  assign csyspwrupreq  = csys_req_q;
  assign ap_abort      = ap_abort_q;

  assign ap_sel   = apsel_q;
  assign ap_addr  = {apbanksel_q, bus_addr};
  assign ap_r_nw  = bus_r_nw;
  assign ap_wdata = bus_wdata;

  assign dp_acc_fault =
    bus_ap_ndp & (stickyerr_q | stickyorun_q | wdataerr_q);
  assign dp_acc_wait =
    busy & (bus_ap_ndp | (bus_r_nw & (bus_addr == 2'd3)));
  assign dp_acc_protocol_err =
    ~bus_ap_ndp & ~bus_r_nw & (bus_addr == 2'd1)
    & (dpbanksel_q != 4'd0);

  // Banked view behind DP address 1.
  always_comb begin
    bank_rdata = 32'd0;
    case (dpbanksel_q)
      4'd0:    bank_rdata = ctrl_stat;
      4'd2:    bank_rdata = TARGETID;
      4'd3:    bank_rdata = {TINSTANCE, DLPIDR[27:0]};
      default: bank_rdata = 32'd0;
    endcase
  end

  // Read data: AP reads are posted and return the old RDBUFF.
  always_comb begin
    bus_rdata = rdbuff_q;
    if (!bus_ap_ndp) begin
      case (bus_addr)
        2'd0:    bus_rdata = DPIDR;
        2'd1:    bus_rdata = bank_rdata;
        default: bus_rdata = rdbuff_q;
      endcase
    end
  end

  // AP sequencer next state and request strobe.
  always_comb begin
    state_d = state_q;
    ap_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_en && bus_ap_ndp) begin
          ap_en   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ap_rdy) state_d = IDLE;
      end
    endcase
    if (dap_abort) state_d = IDLE;
  end

  // AP sequencer state register.
  always_ff @(posedge swclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Direction of the outstanding request and the read buffer.
  always_ff @(posedge swclk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rdbuff_q  <= 32'd0;
    end else begin
      if (ap_en) rd_pend_q <= bus_r_nw;
      if (ap_done && !ap_err && rd_pend_q)
        rdbuff_q <= ap_rdata;
    end
  end

  // Sticky flags: a set strobe beats an ABORT clear.
  always_ff @(posedge swclk) begin
    if (rst) begin
      stickyorun_q <= 1'b0;
      wdataerr_q   <= 1'b0;
      stickyerr_q  <= 1'b0;
      readok_q     <= 1'b0;
    end else begin
      if (abort_wr && bus_wdata[4]) stickyorun_q <= 1'b0;
      if (abort_wr && bus_wdata[3]) wdataerr_q   <= 1'b0;
      if (abort_wr && bus_wdata[2]) stickyerr_q  <= 1'b0;
      if (dp_set_stickyorun)        stickyorun_q <= 1'b1;
      if (dp_set_wdataerr)          wdataerr_q   <= 1'b1;
      if (ap_done && ap_err)        stickyerr_q  <= 1'b1;
      if (dp_clear_readok)          readok_q     <= 1'b0;
      if (ap_en && bus_r_nw)        readok_q     <= 1'b1;
    end
  end

  // CTRL/STAT writable bits and SELECT fields.
  always_ff @(posedge swclk) begin
    if (rst) begin
      orundetect_q <= 1'b0;
      cdbg_req_q   <= 1'b0;
      csys_req_q   <= 1'b0;
      apsel_q      <= 8'd0;
      apbanksel_q  <= 4'd0;
      dpbanksel_q  <= 4'd0;
    end else begin
      if (ctrl_wr) begin
        orundetect_q <= bus_wdata[0];
        cdbg_req_q   <= bus_wdata[28];
        csys_req_q   <= bus_wdata[30];
      end
      if (select_wr) begin
        apsel_q     <= bus_wdata[31:24];
        apbanksel_q <= bus_wdata[7:4];
        dpbanksel_q <= bus_wdata[3:0];
      end
    end
  end

  // One-cycle DAPABORT pulse towards the AP mux.
  always_ff @(posedge swclk) begin
    if (rst) ap_abort_q <= 1'b0;
    else     ap_abort_q <= dap_abort;
  end

  // A new AP header must never be strobed while one is outstanding.
  assert property (@(posedge swclk) disable iff (rst)
    !(bus_en && bus_ap_ndp && busy));

endmodule

// File: doc/opendap_sw_dp_regs.md
Name: opendap_sw_dp_regs

Overview:
Debug Port register file and AP access sequencer that sits directly downstream of the SW-DP serial comms stage. It decodes that stage's parallel DP/AP accesses, holds DPIDR, CTRL/STAT, SELECT, RDBUFF, TARGETID and DLPIDR, and keeps the sticky error flags. It produces the OK/WAIT/FAULT/protocol-error qualifiers and the TARGETSEL match value consumed by the serial stage. It issues posted AP transactions on a simple single-outstanding request/ready bus towards the AP mux.

Parameters:
DPIDR, 32'h0bc12477, value returned on DPIDR read
TARGETID, 32'h00000001, value for DP bank 2 read; bit 0 must be 1
DLPIDR, 32'h00000001, value for DP bank 3 read; bits [31:28] are overridden by TINSTANCE
TINSTANCE, 4'h0, multidrop instance number

Ports:
swclk  in  1  debug clock; all state is on posedge
rst  in  1  synchronous active-high reset
bus_addr  in  2  register address [3:2]
bus_r_nw  in  1  1 = read
bus_ap_ndp  in  1  1 = AP access
bus_wdata  in  32  write data
bus_en  in  1  access strobe, one cycle
bus_rdata  out  32  read data, combinational, valid in the bus_en cycle
targetsel_expected  out  32  {TINSTANCE, TARGETID[27:0]}
dp_set_wdataerr  in  1  write-data parity error strobe
dp_set_stickyorun  in  1  overrun strobe
dp_clear_readok  in  1  clear READOK strobe
dp_orundetect  out  1  CTRL/STAT.ORUNDETECT
dp_acc_fault  out  1  current header must get FAULT
dp_acc_wait  out  1  current header must get WAIT
dp_acc_protocol_err  out  1  current header is a protocol error
ap_en  out  1  AP request pulse
ap_sel  out  8  SELECT.APSEL
ap_addr  out  6  {SELECT.APBANKSEL, bus_addr}
ap_r_nw  out  1  AP request direction
ap_wdata  out  32  AP write data
ap_rdy  in  1  AP completion
ap_rdata  in  32  AP read data, valid with ap_rdy
ap_err  in  1  AP slave error, valid with ap_rdy
ap_abort  out  1  DAPABORT pulse
cdbgpwrupreq, csyspwrupreq  out  1 each  CTRL/STAT bits 28 and 30
cdbgpwrupack, csyspwrupack  in  1 each  already synchronised to swclk

Behaviour:
- Reset: all registers 0. Outputs ap_en, ap_abort, the power-up requests and dp_orundetect are 0; the AP FSM is IDLE.
- Qualifier outputs are combinational from header fields and state. They are sampled by the serial stage in the park cycle.
  - dp_acc_fault = bus_ap_ndp & (STICKYERR | STICKYORUN | WDATAERR).
  - dp_acc_wait = busy & (bus_ap_ndp | (bus_r_nw & bus_addr==3)).
  - dp_acc_protocol_err = !bus_ap_ndp & !bus_r_nw & bus_addr==1 & SELECT.DPBANKSEL!=0.
  - Fault takes priority over wait; the serial stage enforces this.
- DP reads:
  - addr0 returns DPIDR.
  - addr1 returns, by DPBANKSEL: 0 = CTRL/STAT; 2 = TARGETID; 3 = {TINSTANCE, DLPIDR[27:0]}; other banks = 0.
  - addr2 (RESEND) returns RDBUFF; the serial stage ignores this value.
  - addr3 returns RDBUFF.
- DP writes:
  - addr0 = ABORT:
    - bit4 clears STICKYORUN, bit3 clears WDATAERR, bit2 clears STICKYERR.
    - bit0 (DAPABORT) pulses ap_abort for 1 cycle, forces FSM to IDLE, and discards any pending result.
  - addr1 bank0 = CTRL/STAT: writable bits are 0 (ORUNDETECT), 28 and 30.
  - addr2 = SELECT, full 32 bits: APSEL [31:24], APBANKSEL [7:4], DPBANKSEL [3:0].
  - addr3 = TARGETSEL: ignored.
- CTRL/STAT readback:
  - bit0 ORUNDETECT, bit1 STICKYORUN, bit5 STICKYERR, bit6 READOK, bit7 WDATAERR.
  - bit28 CDBGPWRUPREQ, bit29 CDBGPWRUPACK, bit30 CSYSPWRUPREQ, bit31 CSYSPWRUPACK.
  - All other bits read 0.
- Sticky flags:
  - dp_set_* strobes set the matching flag next cycle.
  - A set and an ABORT clear in the same cycle: set wins.
  - dp_clear_readok clears READOK.
- AP FSM, states IDLE and BUSY:
  - In IDLE, bus_en & bus_ap_ndp does the following in the same cycle:
    - drives ap_en=1 with ap_sel/ap_addr/ap_r_nw/ap_wdata from bus and SELECT;
    - for reads, sets READOK next cycle;
    - moves to BUSY.
  - An AP read returns the current RDBUFF on bus_rdata in that same cycle (posted read).
  - A DP RDBUFF read (addr3) in IDLE returns RDBUFF and launches nothing.
  - ap_rdy is ignored in the ap_en cycle.
  - In BUSY, ap_rdy=1 → IDLE next cycle. If the request was a read, RDBUFF <= ap_rdata. If ap_err, set STICKYERR and leave RDBUFF unchanged.
  - ap_rdy in the same cycle the serial stage evaluates a header still yields WAIT, because busy is registered.
  - bus_en & bus_ap_ndp while BUSY is a serial-stage bug. Assert this in simulation; ignore it in hardware.
- Reset during BUSY returns the FSM to IDLE with no ap_abort pulse.

Test Plan:
- Reset → CTRL/STAT read returns 0x00000000; DPIDR read returns 0x0bc12477; targetsel_expected=0x00000001.
- Write CTRL/STAT 0x50000001 with cdbgpwrupack=csyspwrupack=1 → readback 0xF0000001, dp_orundetect=1.
- SELECT=0x01000010, AP read addr2 → ap_en 1 cycle with ap_sel=0x01, ap_addr=0x06. Hold ap_rdy low 3 cycles: RDBUFF header gets dp_acc_wait=1. Then ap_rdy with ap_rdata=0xCAFEF00D → RDBUFF read returns 0xCAFEF00D and READOK=1.
- AP write completes with ap_err=1 → STICKYERR set; next AP header dp_acc_fault=1; ABORT 0x04 → fault clears.
- dp_set_stickyorun and ABORT 0x10 in same cycle → STICKYORUN=1 afterwards.
- DPBANKSEL=2: DP addr1 read → TARGETID; DP addr1 write → dp_acc_protocol_err=1. ABORT 0x01 mid-BUSY → ap_abort pulse, FSM IDLE, late ap_rdy does not update RDBUFF.
